// File: rtl/snow64_instr_fetch_queue.sv
// Instruction fetch front end: sequential word reads, in-order PC-tagged queue to the decoder,
// and redirect handling that flushes the queue and drops responses to superseded reads.
module snow64_instr_fetch_queue #(
    parameter int                    WIDTH_ADDR  = 64,
    parameter int                    WIDTH_INSTR = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [WIDTH_ADDR-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [WIDTH_ADDR-1:0]  mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [WIDTH_INSTR-1:0] mem_resp_data,
    input  logic                   redirect_valid,
    input  logic [WIDTH_ADDR-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH_INSTR-1:0] out_instr,
    output logic [WIDTH_ADDR-1:0]  out_pc
);
    // Handshakes: a transfer happens on a clock edge where valid && ready; valid never
    // depends on the ready of the same channel. mem_resp has no backpressure.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH_ADDR-1:0] ALIGN_MASK = ~WIDTH_ADDR'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH_ADDR-1:0]  fetch_pc;
    logic [CW-1:0]          occupancy, outstanding, stale;
    logic [CW-1:0]          inflight_after, stale_nxt;
    logic [CW:0]            credit_used;
    logic                   req_fire, push, pop;

    logic [WIDTH_INSTR-1:0] q_instr [DEPTH];
    logic [WIDTH_ADDR-1:0]  q_pc    [DEPTH];
    logic [PW-1:0]          q_rd, q_wr;
    logic [WIDTH_ADDR-1:0]  tag_pc  [DEPTH];
    logic [PW-1:0]          tag_rd, tag_wr;

    // outstanding counts every in-flight read, stale ones included; stale <= outstanding.
    assign credit_used    = {1'b0, occupancy} + {1'b0, outstanding};
    assign mem_req_valid  = (state == FETCH) && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign mem_req_addr   = fetch_pc & ALIGN_MASK;
    assign req_fire       = mem_req_valid && mem_req_ready;
    assign push           = mem_resp_valid && (stale == '0) && !redirect_valid;
    assign out_valid      = (occupancy != '0);
    assign pop            = out_valid && out_ready;
    assign out_instr      = q_instr[q_rd];
    assign out_pc         = q_pc[q_rd];

    // On redirect every read still in flight after this cycle becomes stale.
    assign inflight_after = outstanding - CW'(mem_resp_valid);
    assign stale_nxt      = redirect_valid ? inflight_after
                                           : stale - CW'(mem_resp_valid && (stale != '0));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (redirect_valid && (stale_nxt != '0)) state_nxt = FLUSH;
            FLUSH:   if (stale_nxt == '0) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC & ALIGN_MASK;
            occupancy   <= '0;
            outstanding <= '0;
            stale       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
                tag_pc[i]  <= '0;
            end
        end else begin
            state <= state_nxt;
            stale <= stale_nxt;
            if (redirect_valid) begin
                // Any same-cycle pop is subsumed by emptying the queue.
                fetch_pc    <= redirect_pc & ALIGN_MASK;
                outstanding <= inflight_after;
                occupancy   <= '0;
                q_rd        <= '0;
                q_wr        <= '0;
                tag_rd      <= '0;
                tag_wr      <= '0;
            end else begin
                outstanding <= outstanding + CW'(req_fire) - CW'(mem_resp_valid);
                occupancy   <= occupancy + CW'(push) - CW'(pop);
                if (req_fire) begin
                    fetch_pc       <= fetch_pc + WIDTH_ADDR'(4);
                    tag_pc[tag_wr] <= mem_req_addr;
                    tag_wr         <= tag_wr + PW'(1);
                end
                if (push) begin
                    q_instr[q_wr] <= mem_resp_data;
                    q_pc[q_wr]    <= tag_pc[tag_rd];
                    q_wr          <= q_wr + PW'(1);
                    tag_rd        <= tag_rd + PW'(1);
                end
                if (pop) q_rd <= q_rd + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_snow64_instr_fetch_queue.sv
// Bench for snow64_instr_fetch_queue: in-order memory responder, queue-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_snow64_instr_fetch_queue;
    localparam int WA    = 64;
    localparam int WI    = 32;
    localparam int DEPTH = 4;
    localparam logic [WA-1:0] RESET_PC = '0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_req_valid, mem_req_ready;
    logic [WA-1:0] mem_req_addr;
    logic          mem_resp_valid;
    logic [WI-1:0] mem_resp_data;
    logic          redirect_valid;
    logic [WA-1:0] redirect_pc;
    logic          out_valid, out_ready;
    logic [WI-1:0] out_instr;
    logic [WA-1:0] out_pc;

    snow64_instr_fetch_queue #(
        .WIDTH_ADDR (WA),
        .WIDTH_INSTR(WI),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WI-1:0] mem_word(input logic [WA-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
    endfunction

    // Reference model: expected decoder-visible queue, and reads held by memory tagged
    // with the redirect epoch they were issued in.
    typedef struct {
        logic [WA-1:0] pc;
        logic [WI-1:0] instr;
    } ent_t;
    typedef struct {
        logic [WA-1:0] pc;
        int            epoch;
    } pend_t;

    ent_t          exp_q[$];
    pend_t         pend_q[$];
    logic [WA-1:0] m_pc    = RESET_PC;
    int            epoch   = 0;
    bit            started = 0;
    bit            resp_en;

    function automatic bit exp_req();
        int n_stale;
        n_stale = 0;
        foreach (pend_q[i]) if (pend_q[i].epoch != epoch) n_stale++;
        return started && !redirect_valid && (n_stale == 0) &&
               ((exp_q.size() + pend_q.size()) < DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit    fire, resp_push;
        pend_t p;
        if (!rst_n) begin
            exp_q.delete();
            pend_q.delete();
            m_pc    = RESET_PC;
            epoch   = 0;
            started = 0;
        end else begin
            fire      = exp_req() && mem_req_ready;
            resp_push = 0;
            if (mem_resp_valid && pend_q.size() != 0) begin
                p         = pend_q.pop_front();
                resp_push = (p.epoch == epoch) && !redirect_valid;
            end
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (resp_push) begin
                exp_q.push_back('{pc: p.pc, instr: mem_word(p.pc)});
                chk("no_overflow", 64'(exp_q.size() <= DEPTH), 64'd1);
            end
            if (redirect_valid) begin
                exp_q.delete();
                epoch++;
                m_pc = {redirect_pc[WA-1:2], 2'b00};
            end else if (fire) begin
                pend_q.push_back('{pc: m_pc, epoch: epoch});
                m_pc = m_pc + 64'd4;
            end
            started = 1;
        end
    end

    // In-order memory: answers the oldest pending read one cycle after it is issued.
    always @(posedge clk) begin
        #2;
        if (rst_n && resp_en && pend_q.size() != 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(pend_q[0].pc);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_pc", out_pc, exp_q[0].pc);
                chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
            end
            chk("mem_req_valid", 64'(mem_req_valid), 64'(exp_req()));
            if (exp_req()) chk("mem_req_addr", mem_req_addr, m_pc);
        end
    end

    bit            log_en = 0;
    logic [WA-1:0] fire_log[$];
    logic [WA-1:0] pop_pc_log[$];
    logic [WI-1:0] pop_in_log[$];

    always @(negedge clk) begin
        if (log_en && rst_n) begin
            if (mem_req_valid && mem_req_ready) fire_log.push_back(mem_req_addr);
            if (out_valid && out_ready) begin
                pop_pc_log.push_back(out_pc);
                pop_in_log.push_back(out_instr);
            end
        end
    end

    function automatic logic [WA-1:0] fire_at(input int i);
        return (i < fire_log.size()) ? fire_log[i] : '1;
    endfunction
    function automatic logic [WA-1:0] pop_pc_at(input int i);
        return (i < pop_pc_log.size()) ? pop_pc_log[i] : '1;
    endfunction
    function automatic logic [WI-1:0] pop_in_at(input int i);
        return (i < pop_in_log.size()) ? pop_in_log[i] : '1;
    endfunction

    task automatic clear_logs();
        fire_log.delete();
        pop_pc_log.delete();
        pop_in_log.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b1;
        mem_req_ready  = 1'b1;
        out_ready      = 1'b1;
        resp_en        = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);

        // Streaming from RESET_PC with one-cycle memory and a free decoder.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        log_en = 1;
        repeat (10) step();
        log_en = 0;
        chk("t1_addr0", fire_at(0), 64'h0);
        chk("t1_addr1", fire_at(1), 64'h4);
        chk("t1_addr2", fire_at(2), 64'h8);
        chk("t1_pc0", pop_pc_at(0), 64'h0);
        chk("t1_pc1", pop_pc_at(1), 64'h4);
        chk("t1_pc2", pop_pc_at(2), 64'h8);
        chk("t1_instr0", 64'(pop_in_at(0)), 64'hC0DE_0000);

        // Stalled decoder: exactly DEPTH reads, then the queue holds them.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        step();
        redirect_valid = 1'b0;
        clear_logs();
        log_en = 1;
        repeat (12) step();
        log_en = 0;
        chk("t2_nfires", 64'(fire_log.size()), 64'd4);
        chk("t2_first", fire_at(0), 64'h200);
        chk("t2_last", fire_at(3), 64'h20C);
        @(negedge clk);
        chk("t2_full_req", 64'(mem_req_valid), 64'd0);
        chk("t2_full_valid", 64'(out_valid), 64'd1);
        chk("t2_head", out_pc, 64'h200);
        step();
        out_ready = 1'b1;
        clear_logs();
        log_en = 1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t2_refill_req", 64'(mem_req_valid), 64'd1);
        chk("t2_refill_addr", mem_req_addr, 64'h210);
        chk("t2_new_head", out_pc, 64'h204);
        repeat (6) step();
        log_en = 0;
        chk("t2_one_more", 64'(fire_log.size()), 64'd1);
        chk("t2_one_pop", 64'(pop_pc_log.size()), 64'd1);
        chk("t2_popped_pc", pop_pc_at(0), 64'h200);

        // Two reads in flight, then a misaligned redirect.
        out_ready     = 1'b1;
        mem_req_ready = 1'b0;
        resp_en       = 1'b0;
        repeat (8) step();
        mem_req_ready = 1'b1;
        step();
        step();
        mem_req_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1002;
        mem_req_ready  = 1'b1;
        step();
        redirect_valid = 1'b0;
        resp_en        = 1'b1;
        clear_logs();
        log_en = 1;
        repeat (10) step();
        log_en = 0;
        chk("t3_addr", fire_at(0), 64'h1000);
        chk("t3_pc", pop_pc_at(0), 64'h1000);
        chk("t3_instr", 64'(pop_in_at(0)), 64'hC0DE_1000);

        // Redirect together with a decoder handshake and a memory response.
        out_ready = 1'b0;
        repeat (8) step();
        resp_en   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        out_ready      = 1'b1;
        resp_en        = 1'b1;
        clear_logs();
        log_en = 1;
        step();
        redirect_valid = 1'b0;
        log_en = 0;
        chk("t4_head_consumed", 64'(pop_pc_log.size()), 64'd1);
        @(negedge clk);
        chk("t4_empty", 64'(out_valid), 64'd0);
        chk("t4_flush_req", 64'(mem_req_valid), 64'd0);
        step();
        @(negedge clk);
        chk("t4_resume_req", 64'(mem_req_valid), 64'd1);
        chk("t4_resume_addr", mem_req_addr, 64'h3000);

        // Address wrap at the top of the address space.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF9;
        step();
        redirect_valid = 1'b0;
        clear_logs();
        log_en = 1;
        repeat (12) step();
        log_en = 0;
        chk("t5_addr0", fire_at(0), 64'hFFFF_FFFF_FFFF_FFF8);
        chk("t5_addr1", fire_at(1), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_addr2", fire_at(2), 64'h0);
        chk("t5_pc2", pop_pc_at(2), 64'h0);

        // Asynchronous reset with a full queue.
        out_ready = 1'b0;
        repeat (8) step();
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_req", 64'(mem_req_valid), 64'd0);
        chk("t6_pc", out_pc, 64'd0);
        @(posedge clk);
        #1;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        clear_logs();
        log_en = 1;
        repeat (10) step();
        log_en = 0;
        chk("t6_restart_addr", fire_at(0), RESET_PC);
        chk("t6_restart_pc", pop_pc_at(0), RESET_PC);

        // Mixed traffic, checked by the reference model every cycle.
        repeat (200) begin
            out_ready      = ($urandom_range(0, 1) == 1);
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            resp_en        = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = {$urandom(), $urandom()};
            step();
        end
        redirect_valid = 1'b0;
        resp_en        = 1'b1;
        out_ready      = 1'b1;
        mem_req_ready  = 1'b1;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
